// File: rtl/imem_responder_pkg.sv
// Shared defaults and types for the instruction-memory responder.
package imem_responder_pkg;

    localparam int unsigned DEF_ADDR_W  = 5;
    localparam int unsigned DEF_INSTR_W = 8;

    typedef enum logic {S_PROG, S_RUN} imem_state_t;

    typedef struct packed {
        logic [DEF_ADDR_W-1:0]  addr;
        logic [DEF_INSTR_W-1:0] instr;
        logic                   err;
    } fetch_rsp_t;

endpackage

// File: rtl/imem_responder_rsp_fifo.sv
// In-order response FIFO with synchronous clear, simultaneous push/pop and head output.
module imem_responder_rsp_fifo
    import imem_responder_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          push,
    input  fetch_rsp_t    push_data,
    input  logic          pop,
    output fetch_rsp_t    head,
    output logic [CW-1:0] count
);

    localparam int unsigned PW = $clog2(DEPTH);

    fetch_rsp_t    store_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, wr_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_pop = pop && (count_q != '0);

    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                store_q[wr_ptr_q] <= push_data;
                wr_ptr_q          <= ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // The upstream credit check keeps count + s1 <= DEPTH, so a push never meets a full FIFO.
    always_ff @(posedge clk) begin
        if (rst && !clear && push) begin
            assert (count_q < CW'(DEPTH));
        end
    end

    assign head  = store_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: programmed after reset, then serves fetches through s1 and a FIFO.
module imem_responder
    import imem_responder_pkg::*;
#(
    parameter int unsigned ADDR_W    = DEF_ADDR_W,
    parameter int unsigned INSTR_W   = DEF_INSTR_W,
    parameter int unsigned MEM_WORDS = 32,
    parameter int unsigned DEPTH     = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               prog_we,
    input  logic [ADDR_W-1:0]  prog_addr,
    input  logic [INSTR_W-1:0] prog_data,
    input  logic               prog_done,
    input  logic               req_valid,
    input  logic [ADDR_W-1:0]  req_addr,
    output logic               req_ready,
    input  logic               flush,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [INSTR_W-1:0] rsp_instr,
    output logic [ADDR_W-1:0]  rsp_addr,
    output logic               rsp_err,
    output logic               running
);

    localparam int unsigned MEM_AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int unsigned CW     = $clog2(DEPTH + 1);

    imem_state_t        state_q, state_d;
    logic [INSTR_W-1:0] mem [MEM_WORDS];
    logic               s1_valid_q;
    fetch_rsp_t         s1_q, s1_d;
    fetch_rsp_t         head;
    logic [CW-1:0]      fifo_count;
    logic [CW:0]        occupancy;
    logic               accept, prog_wr, req_err;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return {{(32 - ADDR_W){1'b0}}, a} < MEM_WORDS;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_PROG;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q == S_PROG && prog_done) begin
            state_d = S_RUN;
        end
    end

    assign running = (state_q == S_RUN);

    // Memory holds its contents through reset; it is only written while programming.
    assign prog_wr = (state_q == S_PROG) && prog_we && in_range(prog_addr);

    always_ff @(posedge clk) begin
        if (prog_wr) begin
            mem[prog_addr[MEM_AW-1:0]] <= prog_data;
        end
    end

    // Credit uses registered occupancy only, so req_ready never depends on rsp_ready.
    assign occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, s1_valid_q};
    assign req_ready = running && (occupancy < (CW + 1)'(DEPTH));
    assign accept    = req_valid && req_ready;
    assign req_err   = !in_range(req_addr);

    always_comb begin
        s1_d       = '0;
        s1_d.addr  = req_addr;
        s1_d.err   = req_err;
        s1_d.instr = req_err ? '0 : mem[req_addr[MEM_AW-1:0]];
    end

    // A request accepted alongside flush is the jump target and survives into s1.
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_valid_q <= 1'b0;
            s1_q       <= '0;
        end else begin
            s1_valid_q <= accept;
            if (accept) begin
                s1_q <= s1_d;
            end
        end
    end

    imem_responder_rsp_fifo #(
        .DEPTH (DEPTH)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst       (rst),
        .clear     (flush),
        .push      (s1_valid_q),
        .push_data (s1_q),
        .pop       (rsp_valid && rsp_ready),
        .head      (head),
        .count     (fifo_count)
    );

    assign rsp_valid = (fifo_count != '0);
    assign rsp_instr = rsp_valid ? head.instr : '0;
    assign rsp_addr  = rsp_valid ? head.addr : '0;
    assign rsp_err   = rsp_valid && head.err;

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: vector table for streaming plus hand-built corner sequences.
module tb_imem_responder;

    localparam int unsigned ADDR_W    = 5;
    localparam int unsigned INSTR_W   = 8;
    localparam int unsigned MEM_WORDS = 20;
    localparam int unsigned DEPTH     = 2;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               prog_we = 1'b0;
    logic [ADDR_W-1:0]  prog_addr = '0;
    logic [INSTR_W-1:0] prog_data = '0;
    logic               prog_done = 1'b0;
    logic               req_valid = 1'b0;
    logic [ADDR_W-1:0]  req_addr = '0;
    logic               req_ready;
    logic               flush = 1'b0;
    logic               rsp_valid;
    logic               rsp_ready = 1'b0;
    logic [INSTR_W-1:0] rsp_instr;
    logic [ADDR_W-1:0]  rsp_addr;
    logic               rsp_err;
    logic               running;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    imem_responder #(
        .ADDR_W    (ADDR_W),
        .INSTR_W   (INSTR_W),
        .MEM_WORDS (MEM_WORDS),
        .DEPTH     (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .prog_done (prog_done),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_ready (req_ready),
        .flush     (flush),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_instr (rsp_instr),
        .rsp_addr  (rsp_addr),
        .rsp_err   (rsp_err),
        .running   (running)
    );

    typedef struct {
        logic               rv;
        logic [ADDR_W-1:0]  a;
        logic               rdy;
        logic               e_rr;
        logic               e_v;
        logic [ADDR_W-1:0]  e_addr;
        logic [INSTR_W-1:0] e_instr;
    } vec_t;

    vec_t t1 [8];

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_idle(input string name);
        check({name, " rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({name, " rsp_instr"}, 32'(rsp_instr), 32'd0);
        check({name, " rsp_addr"},  32'(rsp_addr),  32'd0);
        check({name, " rsp_err"},   32'(rsp_err),   32'd0);
    endtask

    // Single fetch from an empty pipe: checks 2-cycle latency, payload, and zeroed outputs after pop.
    task automatic fetch_one(input string name, input logic [ADDR_W-1:0] a,
                             input logic [INSTR_W-1:0] exp_instr, input logic exp_err);
        int waits;
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_addr  = a;
        waits     = 0;
        while (!req_ready && waits < 10) begin
            cycle();
            waits++;
        end
        check({name, " req_ready"}, 32'(req_ready), 32'd1);
        cycle();
        req_valid = 1'b0;
        waits     = 1;
        while (!rsp_valid && waits < 10) begin
            cycle();
            waits++;
        end
        check({name, " latency"},   32'(waits),     32'd2);
        check({name, " rsp_addr"},  32'(rsp_addr),  32'(a));
        check({name, " rsp_instr"}, 32'(rsp_instr), 32'(exp_instr));
        check({name, " rsp_err"},   32'(rsp_err),   32'(exp_err));
        cycle();
        check_idle({name, " after pop"});
    endtask

    // Drains for a fixed window, expecting exactly exp_n responses all carrying exp_addr.
    task automatic drain(input string name, input logic [ADDR_W-1:0] exp_addr,
                         input logic [INSTR_W-1:0] exp_instr, input int exp_n);
        int n;
        n         = 0;
        rsp_ready = 1'b1;
        repeat (6) begin
            if (rsp_valid) begin
                n++;
                check({name, " rsp_addr"},  32'(rsp_addr),  32'(exp_addr));
                check({name, " rsp_instr"}, 32'(rsp_instr), 32'(exp_instr));
            end
            cycle();
        end
        check({name, " count"}, 32'(n), 32'(exp_n));
    endtask

    initial begin
        int acc;
        int n;

        t1[0] = '{1'b1, 5'd0, 1'b1, 1'b1, 1'b0, 5'd0, 8'h00};
        t1[1] = '{1'b1, 5'd1, 1'b1, 1'b1, 1'b0, 5'd0, 8'h00};
        t1[2] = '{1'b1, 5'd2, 1'b1, 1'b0, 1'b1, 5'd0, 8'hA0};
        t1[3] = '{1'b1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd1, 8'hA1};
        t1[4] = '{1'b1, 5'd3, 1'b1, 1'b1, 1'b0, 5'd0, 8'h00};
        t1[5] = '{1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd2, 8'hA2};
        t1[6] = '{1'b0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd3, 8'hA3};
        t1[7] = '{1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 5'd0, 8'h00};

        // Reset values
        cycle();
        cycle();
        check_idle("reset");
        check("reset req_ready", 32'(req_ready), 32'd0);
        check("reset running",   32'(running),   32'd0);
        rst = 1'b1;

        // Requests are refused while programming
        req_valid = 1'b1;
        req_addr  = 5'd0;
        cycle();
        check("prog req_ready", 32'(req_ready), 32'd0);
        cycle();
        check("prog req_ready 2", 32'(req_ready), 32'd0);
        check("prog rsp_valid",   32'(rsp_valid), 32'd0);
        req_valid = 1'b0;

        // mem[i] = A0 + i; last write shares its cycle with prog_done
        for (int i = 0; i < 19; i++) begin
            prog_we   = 1'b1;
            prog_addr = 5'(i);
            prog_data = 8'(8'hA0 + i);
            cycle();
        end
        prog_addr = 5'd19;
        prog_data = 8'hB3;
        prog_done = 1'b1;
        check("pre-run running", 32'(running), 32'd0);
        cycle();
        prog_we   = 1'b0;
        prog_done = 1'b0;
        check("run running",   32'(running),   32'd1);
        check("run req_ready", 32'(req_ready), 32'd1);

        // Streaming fetch 0..3 with rsp_ready held high
        for (int i = 0; i < 8; i++) begin
            req_valid = t1[i].rv;
            req_addr  = t1[i].a;
            rsp_ready = t1[i].rdy;
            check($sformatf("t1[%0d] req_ready", i), 32'(req_ready), 32'(t1[i].e_rr));
            check($sformatf("t1[%0d] rsp_valid", i), 32'(rsp_valid), 32'(t1[i].e_v));
            check($sformatf("t1[%0d] rsp_addr", i),  32'(rsp_addr),  32'(t1[i].e_addr));
            check($sformatf("t1[%0d] rsp_instr", i), 32'(rsp_instr), 32'(t1[i].e_instr));
            check($sformatf("t1[%0d] rsp_err", i),   32'(rsp_err),   32'd0);
            cycle();
        end
        req_valid = 1'b0;

        // Backpressure: exactly DEPTH accepts, then drain in order
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_addr  = 5'd10;
        acc       = 0;
        for (int k = 0; k < 8; k++) begin
            if (req_ready) acc++;
            cycle();
            req_addr = 5'(10 + acc);
        end
        req_valid = 1'b0;
        check("bp accepts",   32'(acc),       32'(DEPTH));
        check("bp req_ready", 32'(req_ready), 32'd0);
        check("bp rsp_valid", 32'(rsp_valid), 32'd1);
        check("bp hold addr", 32'(rsp_addr),  32'd10);
        rsp_ready = 1'b1;
        n         = 0;
        for (int k = 0; k < 8; k++) begin
            if (rsp_valid) begin
                check($sformatf("bp drain[%0d] addr", n),  32'(rsp_addr),  32'(10 + n));
                check($sformatf("bp drain[%0d] instr", n), 32'(rsp_instr), 32'(8'hA0 + 10 + n));
                n++;
            end
            cycle();
        end
        check("bp drain count", 32'(n), 32'(DEPTH));

        // Flush with 4 and 5 in flight; request 9 presented with the flush
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_addr  = 5'd4;
        check("fl1 ready 4", 32'(req_ready), 32'd1);
        cycle();
        req_addr = 5'd5;
        check("fl1 ready 5", 32'(req_ready), 32'd1);
        cycle();
        check("fl1 in-flight valid", 32'(rsp_valid), 32'd1);
        check("fl1 in-flight addr",  32'(rsp_addr),  32'd4);
        flush    = 1'b1;
        req_addr = 5'd9;
        cycle();
        flush = 1'b0;
        check("fl1 post-flush valid", 32'(rsp_valid), 32'd0);
        check("fl1 post-flush ready", 32'(req_ready), 32'd1);
        cycle();
        req_valid = 1'b0;
        drain("fl1 drain", 5'd9, 8'hA9, 1);

        // Flush while the accepted jump target lands in the same cycle
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_addr  = 5'd6;
        cycle();
        check("fl2 ready", 32'(req_ready), 32'd1);
        flush    = 1'b1;
        req_addr = 5'd9;
        cycle();
        flush     = 1'b0;
        req_valid = 1'b0;
        check("fl2 post-flush valid", 32'(rsp_valid), 32'd0);
        drain("fl2 drain", 5'd9, 8'hA9, 1);

        // Out-of-range and last in-range word
        fetch_one("oob 25", 5'd25, 8'h00, 1'b1);
        fetch_one("last 19", 5'd19, 8'hB3, 1'b0);

        // Writes are ignored once running
        prog_we   = 1'b1;
        prog_addr = 5'd0;
        prog_data = 8'hFF;
        cycle();
        prog_we = 1'b0;
        fetch_one("ro 0", 5'd0, 8'hA0, 1'b0);

        // Mid-stream reset with two FIFO entries
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_addr  = 5'd1;
        cycle();
        req_addr = 5'd2;
        cycle();
        req_valid = 1'b0;
        cycle();
        check("mr full valid", 32'(rsp_valid), 32'd1);
        check("mr full addr",  32'(rsp_addr),  32'd1);
        check("mr full ready", 32'(req_ready), 32'd0);
        rst = 1'b0;
        cycle();
        rst = 1'b1;
        check_idle("mr reset");
        check("mr running",   32'(running),   32'd0);
        check("mr req_ready", 32'(req_ready), 32'd0);
        rsp_ready = 1'b1;
        cycle();
        check("mr stays empty", 32'(rsp_valid), 32'd0);
        prog_done = 1'b1;
        cycle();
        prog_done = 1'b0;
        check("mr rerun", 32'(running), 32'd1);
        fetch_one("mr mem 3", 5'd3, 8'hA3, 1'b0);
        fetch_one("mr mem 0", 5'd0, 8'hA0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
